// File: rtl/mpu_dmem_arbiter.sv
// mpu_dmem_arbiter
//   Arbitrates two requesters (A = MPU dBus, B = host port such as mailbox/DMA)
//   onto a single port of the MPU data RAM.  One command is in flight at a time:
//   IDLE -> CMD (strobe + ack) -> [RDATA (rvalid)] -> IDLE.  Ties are broken by
//   weighted round-robin, with A_BURST / B_BURST consecutive grants allowed per
//   side while the other side is also waiting.
//
//   Ports
//     clk, reset_n                  clock, async active-low reset
//     {a,b}_req/we/addr/wdata/bytesel  requester command (held until ack)
//     {a,b}_ack                     one-cycle pulse: command issued to RAM
//     {a,b}_rvalid, {a,b}_rdata     read return (rdata follows ram_q)
//     ram_addr/wdata/bytesel        registered RAM command fields
//     ram_rden, ram_wren            one-cycle RAM strobes
//     ram_q                         RAM read data, one cycle after ram_rden
//
//   Optional build macro DMEM_ARB_PERF_EN adds perf_clr and three saturating
//   32-bit counters: perf_a_grants, perf_b_grants, perf_conflicts.
module mpu_dmem_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned A_BURST = 1,
   parameter int unsigned B_BURST = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [31:0]       a_wdata,
   input  logic [1:0]        a_bytesel,
   output logic              a_ack,
   output logic              a_rvalid,
   output logic [31:0]       a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [31:0]       b_wdata,
   input  logic [1:0]        b_bytesel,
   output logic              b_ack,
   output logic              b_rvalid,
   output logic [31:0]       b_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [1:0]        ram_bytesel,
   output logic              ram_rden,
   output logic              ram_wren,
`ifdef DMEM_ARB_PERF_EN
   input  logic              perf_clr,
   output logic [31:0]       perf_a_grants,
   output logic [31:0]       perf_b_grants,
   output logic [31:0]       perf_conflicts,
`endif
   input  logic [31:0]       ram_q
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RDATA} state_t;

   state_t            state, state_nxt;
   logic              side_b, side_b_nxt;     // side owning the access in flight
   logic              last_b, last_b_nxt;     // side served by the most recent grant
   logic [CNT_W-1:0]  burst_cnt, burst_nxt;
   logic              cmd_we, cmd_we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [31:0]       wdata_nxt;
   logic [1:0]        sel_nxt;
   logic              a_ack_nxt, b_ack_nxt, a_rvalid_nxt, b_rvalid_nxt;
   logic              rden_nxt, wren_nxt;
   logic              grant, pick_b, sel_we;

   // Read data is the RAM output, qualified by rvalid.
   assign a_rdata = ram_q;
   assign b_rdata = ram_q;

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         side_b      <= 1'b0;
         last_b      <= 1'b1;
         burst_cnt   <= '0;
         cmd_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         ram_bytesel <= '0;
         ram_rden    <= 1'b0;
         ram_wren    <= 1'b0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         a_rvalid    <= 1'b0;
         b_rvalid    <= 1'b0;
      end else begin
         state       <= state_nxt;
         side_b      <= side_b_nxt;
         last_b      <= last_b_nxt;
         burst_cnt   <= burst_nxt;
         cmd_we      <= cmd_we_nxt;
         ram_addr    <= addr_nxt;
         ram_wdata   <= wdata_nxt;
         ram_bytesel <= sel_nxt;
         ram_rden    <= rden_nxt;
         ram_wren    <= wren_nxt;
         a_ack       <= a_ack_nxt;
         b_ack       <= b_ack_nxt;
         a_rvalid    <= a_rvalid_nxt;
         b_rvalid    <= b_rvalid_nxt;
      end
   end

   // Arbitration, sequencing and next-cycle output values.
   always_comb begin
      state_nxt    = state;
      side_b_nxt   = side_b;
      last_b_nxt   = last_b;
      burst_nxt    = burst_cnt;
      cmd_we_nxt   = cmd_we;
      addr_nxt     = ram_addr;
      wdata_nxt    = ram_wdata;
      sel_nxt      = ram_bytesel;
      a_ack_nxt    = 1'b0;
      b_ack_nxt    = 1'b0;
      a_rvalid_nxt = 1'b0;
      b_rvalid_nxt = 1'b0;
      rden_nxt     = 1'b0;
      wren_nxt     = 1'b0;
      grant        = 1'b0;
      pick_b       = 1'b0;
      sel_we       = 1'b0;

      case (state)
         ST_IDLE: begin
            grant = a_req | b_req;
            if (a_req && b_req) begin
               // A zero count means nobody has been served yet: plain alternation
               // from last_b (reset to B) so A takes the first tie.
               if (burst_cnt == '0)
                  pick_b = !last_b;
               else if (last_b)
                  pick_b = (32'(burst_cnt) < B_BURST);
               else
                  pick_b = !(32'(burst_cnt) < A_BURST);
            end else begin
               pick_b = b_req;
            end

            if (grant) begin
               sel_we     = pick_b ? b_we : a_we;
               state_nxt  = ST_CMD;
               side_b_nxt = pick_b;
               last_b_nxt = pick_b;
               if (pick_b == last_b)
                  burst_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + CNT_W'(1);
               else
                  burst_nxt = CNT_W'(1);
               cmd_we_nxt = sel_we;
               addr_nxt   = pick_b ? b_addr    : a_addr;
               wdata_nxt  = pick_b ? b_wdata   : a_wdata;
               sel_nxt    = pick_b ? b_bytesel : a_bytesel;
               a_ack_nxt  = !pick_b;
               b_ack_nxt  = pick_b;
               rden_nxt   = !sel_we;
               wren_nxt   = sel_we;
            end
         end
         ST_CMD: begin
            if (cmd_we) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt    = ST_RDATA;
               a_rvalid_nxt = !side_b;
               b_rvalid_nxt = side_b;
            end
         end
         ST_RDATA: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

`ifdef DMEM_ARB_PERF_EN
   logic grant_a, grant_b, conflict;

   assign grant_a  = grant & !pick_b;
   assign grant_b  = grant & pick_b;
   assign conflict = (state == ST_IDLE) & a_req & b_req;

   // Saturating event counters; a synchronous clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_a_grants  <= '0;
         perf_b_grants  <= '0;
         perf_conflicts <= '0;
      end else if (perf_clr) begin
         perf_a_grants  <= '0;
         perf_b_grants  <= '0;
         perf_conflicts <= '0;
      end else begin
         if (grant_a && (perf_a_grants != '1))
            perf_a_grants <= perf_a_grants + 32'd1;
         if (grant_b && (perf_b_grants != '1))
            perf_b_grants <= perf_b_grants + 32'd1;
         if (conflict && (perf_conflicts != '1))
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mpu_dmem_arbiter.sv
// Directed bench for mpu_dmem_arbiter with a command/read-data scoreboard.
// Two instances: dut (A_BURST = B_BURST = 1) and dut3 (A_BURST = 3).
`timescale 1ns/1ps
module tb_mpu_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [15:0] a_addr = '0, b_addr = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic [1:0]  a_bytesel = '0, b_bytesel = '0;
   logic [31:0] ram_q = '0;

   logic        a_ack, b_ack, a_rvalid, b_rvalid;
   logic [31:0] a_rdata, b_rdata, ram_wdata;
   logic [15:0] ram_addr;
   logic [1:0]  ram_bytesel;
   logic        ram_rden, ram_wren;

   logic        a_ack3, b_ack3, a_rvalid3, b_rvalid3;
   logic [31:0] a_rdata3, b_rdata3, ram_wdata3;
   logic [15:0] ram_addr3;
   logic [1:0]  ram_bytesel3;
   logic        ram_rden3, ram_wren3;

`ifdef DMEM_ARB_PERF_EN
   logic        perf_clr = 1'b0;
   logic [31:0] perf_a_grants, perf_b_grants, perf_conflicts;
   logic [31:0] perf_a_grants3, perf_b_grants3, perf_conflicts3;
`endif

   int tests = 0;
   int fails = 0;
   bit watch3 = 1'b0;

   typedef struct {
      logic        side_b;
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [1:0]  sel;
   } cmd_t;

   typedef struct {
      logic        side_b;
      logic [31:0] data;
   } rd_t;

   cmd_t cmd_q[$];
   rd_t  rd_q[$];
   logic side3_q[$];

   mpu_dmem_arbiter #(.ADDR_W(16), .A_BURST(1), .B_BURST(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_bytesel(a_bytesel),
      .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_bytesel(b_bytesel),
      .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_bytesel(ram_bytesel),
      .ram_rden(ram_rden), .ram_wren(ram_wren),
`ifdef DMEM_ARB_PERF_EN
      .perf_clr(perf_clr), .perf_a_grants(perf_a_grants),
      .perf_b_grants(perf_b_grants), .perf_conflicts(perf_conflicts),
`endif
      .ram_q(ram_q)
   );

   mpu_dmem_arbiter #(.ADDR_W(16), .A_BURST(3), .B_BURST(1)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_bytesel(a_bytesel),
      .a_ack(a_ack3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_bytesel(b_bytesel),
      .b_ack(b_ack3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
      .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_bytesel(ram_bytesel3),
      .ram_rden(ram_rden3), .ram_wren(ram_wren3),
`ifdef DMEM_ARB_PERF_EN
      .perf_clr(perf_clr), .perf_a_grants(perf_a_grants3),
      .perf_b_grants(perf_b_grants3), .perf_conflicts(perf_conflicts3),
`endif
      .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // RAM contents as seen by reads: one fixed word, otherwise address-derived.
   function automatic logic [31:0] rdval(input logic [15:0] addr);
      return (addr == 16'h0010) ? 32'hDEAD_BEEF : {16'hC0DE, addr};
   endfunction

   // RAM read port: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (ram_rden) ram_q <= rdval(ram_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_cmd(input logic side_b, input logic we, input logic [15:0] addr,
                             input logic [31:0] wdata, input logic [1:0] sel);
      cmd_t c;
      rd_t  r;
      c.side_b = side_b; c.we = we; c.addr = addr; c.wdata = wdata; c.sel = sel;
      cmd_q.push_back(c);
      if (!we) begin
         r.side_b = side_b;
         r.data   = rdval(addr);
         rd_q.push_back(r);
      end
   endtask

   // Per-cycle protocol checks and scoreboard pops for dut.
   task automatic observe();
      cmd_t c;
      rd_t  r;
      chk("ack_overlap",    32'(a_ack & b_ack), 32'd0);
      chk("rvalid_overlap", 32'(a_rvalid & b_rvalid), 32'd0);
      chk("strobe_overlap", 32'(ram_rden & ram_wren), 32'd0);
      chk("strobe_vs_ack",  32'(ram_rden | ram_wren), 32'(a_ack | b_ack));
      if (a_ack || b_ack) begin
         if (cmd_q.size() == 0) begin
            chk("ack_unexpected", 32'(a_ack | b_ack), 32'd0);
         end else begin
            c = cmd_q.pop_front();
            chk("ack_side",    32'(b_ack), 32'(c.side_b));
            chk("ram_addr",    32'(ram_addr), 32'(c.addr));
            chk("ram_wren",    32'(ram_wren), 32'(c.we));
            chk("ram_bytesel", 32'(ram_bytesel), 32'(c.sel));
            if (c.we) chk("ram_wdata", ram_wdata, c.wdata);
         end
      end
      if (a_rvalid || b_rvalid) begin
         if (rd_q.size() == 0) begin
            chk("rvalid_unexpected", 32'(a_rvalid | b_rvalid), 32'd0);
         end else begin
            r = rd_q.pop_front();
            chk("rvalid_side", 32'(b_rvalid), 32'(r.side_b));
            chk("rdata", b_rvalid ? b_rdata : a_rdata, r.data);
         end
      end
   endtask

   // Grant order checks for dut3.
   task automatic observe3();
      logic s;
      chk("dut3_ack_overlap", 32'(a_ack3 & b_ack3), 32'd0);
      if (a_ack3 || b_ack3) begin
         if (side3_q.size() == 0) begin
            chk("dut3_ack_unexpected", 32'(a_ack3 | b_ack3), 32'd0);
         end else begin
            s = side3_q.pop_front();
            chk("dut3_grant_side", 32'(b_ack3), 32'(s));
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      observe();
      if (watch3) observe3();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cmd_q.delete();
      rd_q.delete();
      side3_q.delete();
      #1;
      chk("rst_a_ack",    32'(a_ack), 32'd0);
      chk("rst_b_ack",    32'(b_ack), 32'd0);
      chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("rst_ram_rden", 32'(ram_rden), 32'd0);
      chk("rst_ram_wren", 32'(ram_wren), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_ram_bytesel", 32'(ram_bytesel), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      cycle();

      // Single A read of 0x0010
      a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010; a_bytesel = 2'b11;
      expect_cmd(1'b0, 1'b0, 16'h0010, 32'h0, 2'b11);
      cycle();
      chk("rd_a_ack_c1",  32'(a_ack), 32'd1);
      chk("rd_rden_c1",   32'(ram_rden), 32'd1);
      a_req = 1'b0;
      cycle();
      chk("rd_a_rvalid_c2", 32'(a_rvalid), 32'd1);
      chk("rd_a_rdata_c2",  a_rdata, 32'hDEAD_BEEF);
      cycle();
      chk("rd_a_rvalid_c3", 32'(a_rvalid), 32'd0);

      // B write 0x8004 / 0x12345678 / bytesel 10
      b_req = 1'b1; b_we = 1'b1; b_addr = 16'h8004; b_wdata = 32'h1234_5678; b_bytesel = 2'b10;
      expect_cmd(1'b1, 1'b1, 16'h8004, 32'h1234_5678, 2'b10);
      cycle();
      chk("wr_b_ack",    32'(b_ack), 32'd1);
      chk("wr_ram_wren", 32'(ram_wren), 32'd1);
      b_req = 1'b0; b_we = 1'b0;
      cycle();
      chk("wr_no_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("wr_wren_single", 32'(ram_wren), 32'd0);
      cycle();

      // A raises and drops req inside one IDLE cycle: nothing issued
      a_req = 1'b1; a_addr = 16'h0020;
      #2;
      a_req = 1'b0;
      repeat (3) begin
         cycle();
         chk("drop_idle_no_strobe", 32'(ram_rden | ram_wren), 32'd0);
      end

      // A read, req dropped during CMD: ack and rvalid still pulse
      a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0044; a_bytesel = 2'b01;
      expect_cmd(1'b0, 1'b0, 16'h0044, 32'h0, 2'b01);
      cycle();
      a_req = 1'b0;
      chk("drop_cmd_ack", 32'(a_ack), 32'd1);
      cycle();
      chk("drop_cmd_rvalid", 32'(a_rvalid), 32'd1);
      cycle();

      // Reset during RDATA: outputs clear at once, nothing after release
      a_req = 1'b1; a_addr = 16'h0048; a_bytesel = 2'b11;
      expect_cmd(1'b0, 1'b0, 16'h0048, 32'h0, 2'b11);
      cycle();
      a_req = 1'b0;
      cycle();
      do_reset();
      repeat (3) begin
         cycle();
         chk("post_rst_rdata_no_rvalid", 32'(a_rvalid | b_rvalid), 32'd0);
      end

      // Reset during CMD: pending read never returns
      a_req = 1'b1; a_addr = 16'h004C;
      expect_cmd(1'b0, 1'b0, 16'h004C, 32'h0, 2'b11);
      cycle();
      a_req = 1'b0;
      do_reset();
      repeat (3) begin
         cycle();
         chk("post_rst_cmd_no_rvalid", 32'(a_rvalid | b_rvalid), 32'd0);
      end

      // Both held high: dut alternates, dut3 gives A three grants per B
      do_reset();
      a_req = 1'b1; a_we = 1'b1; a_addr = 16'h1000; a_wdata = 32'hAAAA_0001; a_bytesel = 2'b11;
      b_req = 1'b1; b_we = 1'b1; b_addr = 16'h2000; b_wdata = 32'hBBBB_0002; b_bytesel = 2'b01;
      for (int i = 0; i < 8; i++) begin
         if (i[0]) expect_cmd(1'b1, 1'b1, 16'h2000, 32'hBBBB_0002, 2'b01);
         else      expect_cmd(1'b0, 1'b1, 16'h1000, 32'hAAAA_0001, 2'b11);
         side3_q.push_back((i % 4) == 3);
      end
      watch3 = 1'b1;
      repeat (16) cycle();
      a_req = 1'b0; b_req = 1'b0;
      repeat (3) cycle();
      watch3 = 1'b0;
      chk("contend_dut_all_grants",  32'(cmd_q.size()), 32'd0);
      chk("contend_dut3_all_grants", 32'(side3_q.size()), 32'd0);

`ifdef DMEM_ARB_PERF_EN
      // Conflict counter and clear; grant counter saturation
      do_reset();
      a_req = 1'b1; b_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i[0]) expect_cmd(1'b1, 1'b1, 16'h2000, 32'hBBBB_0002, 2'b01);
         else      expect_cmd(1'b0, 1'b1, 16'h1000, 32'hAAAA_0001, 2'b11);
      end
      repeat (7) cycle();
      a_req = 1'b0; b_req = 1'b0;
      cycle();
      chk("perf_conflicts_4", perf_conflicts, 32'd4);
      chk("perf_a_grants_2",  perf_a_grants, 32'd2);
      perf_clr = 1'b1;
      cycle();
      perf_clr = 1'b0;
      chk("perf_conflicts_clr", perf_conflicts, 32'd0);
      dut.perf_a_grants = 32'hFFFF_FFFF;
      a_req = 1'b1;
      expect_cmd(1'b0, 1'b1, 16'h1000, 32'hAAAA_0001, 2'b11);
      cycle();
      a_req = 1'b0;
      cycle();
      chk("perf_a_grants_sat", perf_a_grants, 32'hFFFF_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
